// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter between the fetch and
// data requesters.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF      = 32;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned DATA_STREAK_DEF = 4;

  // Wide enough for the largest permitted DATA_STREAK (15).
  localparam int unsigned STREAK_W = 4;

  // Owner of the access issued last cycle, i.e. who the SRAM output belongs to now.
  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnDRd  = 2'd2,
    OwnDWr  = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational priority selector: data first, except when a waiting fetch has been
// passed over DATA_STREAK times in a row.
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_STREAK = DATA_STREAK_DEF
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                sel_if,
  output logic                sel_d
);

  logic w_streak_full;

  assign w_streak_full = (streak == STREAK_W'(DATA_STREAK));

  always_comb begin
    sel_d  = 1'b0;
    sel_if = 1'b0;
    if (d_req && !(if_req && w_streak_full)) begin
      sel_d = 1'b1;
    end else if (if_req) begin
      sel_if = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous SRAM port between instruction fetch and data accesses, and
// routes each one-cycle-latency response back to the requester that issued it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DATA_STREAK = DATA_STREAK_DEF
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_wack,

  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_we,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  owner_e              r_owner;
  owner_e              w_owner_d;
  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_d;
  logic                w_sel_if;
  logic                w_sel_d;

  mem_arb_sel #(
    .DATA_STREAK(DATA_STREAK)
  ) u_sel (
    .if_req (if_req),
    .d_req  (d_req),
    .streak (r_streak),
    .sel_if (w_sel_if),
    .sel_d  (w_sel_d)
  );

  // Grants are suppressed during reset so nothing issued then can produce a response.
  assign if_gnt = w_sel_if & rst_n;
  assign d_gnt  = w_sel_d & rst_n;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (d_gnt) begin
      sram_en    = 1'b1;
      sram_we    = d_we;
      sram_addr  = d_addr;
      sram_wdata = d_wdata;
    end else if (if_gnt) begin
      sram_en   = 1'b1;
      sram_addr = if_addr;
    end
  end

  always_comb begin
    w_owner_d = OwnNone;
    if (d_gnt) begin
      w_owner_d = (|d_we) ? OwnDWr : OwnDRd;
    end else if (if_gnt && !if_flush) begin
      w_owner_d = OwnIf;
    end
  end

  // The streak only counts data grants that actually kept a fetch waiting.
  always_comb begin
    w_streak_d = r_streak;
    if (!if_req || if_gnt) begin
      w_streak_d = '0;
    end else if (d_gnt && (r_streak < STREAK_W'(DATA_STREAK))) begin
      w_streak_d = r_streak + STREAK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner  <= OwnNone;
      r_streak <= '0;
    end else begin
      r_owner  <= w_owner_d;
      r_streak <= w_streak_d;
    end
  end

  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    d_wack    = 1'b0;
    if (rst_n) begin
      unique case (r_owner)
        OwnIf: begin
          if_rvalid = !if_flush;
          if_rdata  = sram_rdata;
        end
        OwnDRd: begin
          d_rvalid = 1'b1;
          d_rdata  = sram_rdata;
        end
        OwnDWr:  d_wack = 1'b1;
        OwnNone: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus a hand-written
// contention sequence, against a small behavioural SRAM.
module tb_mem_port_arbiter;

  localparam logic [31:0] IA = 32'h1C00_0000;
  localparam logic [31:0] IR = 32'h0280_0404;
  localparam logic [31:0] DA = 32'h0000_0100;
  localparam logic [31:0] DR = 32'h1234_BEEF;
  localparam logic [31:0] BB = 32'hBEEF_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic [3:0]  d_we = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt, d_rvalid, d_wack;
  logic [31:0] d_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = '0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_wack     (d_wack),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Behavioural SRAM: 256 words, byte writes, one-cycle read latency.
  logic [31:0] mem [256];
  initial begin
    for (int k = 0; k < 256; k++) mem[k] = '0;
    mem[0]  = IR;            // word seen by fetches to IA
    mem[64] = 32'h1234_5678; // word at DA
  end

  always @(posedge clk) begin
    if (sram_en) begin
      if (|sram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
        end
      end else begin
        sram_rdata <= mem[sram_addr[9:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_en;
    logic [3:0]  e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
    logic        e_d_wack;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    logic [11:0] pat;
    logic        prev_f;

    // Each row is one cycle: inputs | expected outputs in that same cycle.
    //          rst ifr ifa fl dr dwe da  dwd | ig dg en we ad  wd  irv ird drv drd wk
    vecs[0]  = '{0, 0, 0,  0, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, 0,  0, 0,  0};
    vecs[1]  = '{0, 0, 0,  0, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, 0,  0, 0,  0};
    vecs[2]  = '{1, 0, 0,  0, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, 0,  0, 0,  0};
    vecs[3]  = '{1, 0, 0,  0, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, 0,  0, 0,  0};
    vecs[4]  = '{1, 1, IA, 0, 0, 0, 0,  0,    1, 0, 1, 0, IA, 0,  0, 0,  0, 0,  0};
    vecs[5]  = '{1, 0, 0,  0, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  1, IR, 0, 0,  0};
    vecs[6]  = '{1, 0, 0,  0, 1, 3, DA, BB,   0, 1, 1, 3, DA, BB, 0, 0,  0, 0,  0};
    vecs[7]  = '{1, 0, 0,  0, 1, 0, DA, 0,    0, 1, 1, 0, DA, 0,  0, 0,  0, 0,  1};
    vecs[8]  = '{1, 0, 0,  0, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, 0,  1, DR, 0};
    vecs[9]  = '{1, 1, IA, 0, 0, 0, 0,  0,    1, 0, 1, 0, IA, 0,  0, 0,  0, 0,  0};
    // Flush while the fetch response is due: valid dropped, data still routed.
    vecs[10] = '{1, 0, 0,  1, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, IR, 0, 0,  0};
    // Fetch granted under flush: slot consumed, nothing comes back.
    vecs[11] = '{1, 1, IA, 1, 0, 0, 0,  0,    1, 0, 1, 0, IA, 0,  0, 0,  0, 0,  0};
    vecs[12] = '{1, 0, 0,  0, 1, 0, DA, 0,    0, 1, 1, 0, DA, 0,  0, 0,  0, 0,  0};
    vecs[13] = '{1, 0, 0,  1, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, 0,  1, DR, 0};
    // Reset lands on the cycle a load response is due.
    vecs[14] = '{1, 0, 0,  0, 1, 0, DA, 0,    0, 1, 1, 0, DA, 0,  0, 0,  0, 0,  0};
    vecs[15] = '{0, 0, 0,  0, 1, 0, DA, 0,    0, 0, 0, 0, 0,  0,  0, 0,  0, 0,  0};
    vecs[16] = '{1, 0, 0,  0, 0, 0, 0,  0,    0, 0, 0, 0, 0,  0,  0, 0,  0, 0,  0};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n    = vecs[i].rst_n;
      if_req   = vecs[i].if_req;
      if_addr  = vecs[i].if_addr;
      if_flush = vecs[i].if_flush;
      d_req    = vecs[i].d_req;
      d_we     = vecs[i].d_we;
      d_addr   = vecs[i].d_addr;
      d_wdata  = vecs[i].d_wdata;
      #1;
      check($sformatf("v%0d if_gnt", i),     32'(if_gnt),     32'(vecs[i].e_if_gnt));
      check($sformatf("v%0d d_gnt", i),      32'(d_gnt),      32'(vecs[i].e_d_gnt));
      check($sformatf("v%0d sram_en", i),    32'(sram_en),    32'(vecs[i].e_en));
      check($sformatf("v%0d sram_we", i),    32'(sram_we),    32'(vecs[i].e_we));
      check($sformatf("v%0d sram_addr", i),  sram_addr,       vecs[i].e_addr);
      check($sformatf("v%0d sram_wdata", i), sram_wdata,      vecs[i].e_wdata);
      check($sformatf("v%0d if_rvalid", i),  32'(if_rvalid),  32'(vecs[i].e_if_rvalid));
      check($sformatf("v%0d if_rdata", i),   if_rdata,        vecs[i].e_if_rdata);
      check($sformatf("v%0d d_rvalid", i),   32'(d_rvalid),   32'(vecs[i].e_d_rvalid));
      check($sformatf("v%0d d_rdata", i),    d_rdata,         vecs[i].e_d_rdata);
      check($sformatf("v%0d d_wack", i),     32'(d_wack),     32'(vecs[i].e_d_wack));
    end

    // Contention: both request every cycle; bit set = fetch expected to win.
    pat    = 12'b0010_0001_0000;
    prev_f = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if_req   = 1'b1;
      if_addr  = IA;
      if_flush = 1'b0;
      d_req    = 1'b1;
      d_we     = '0;
      d_addr   = DA;
      d_wdata  = '0;
      #1;
      check($sformatf("c%0d if_gnt", i), 32'(if_gnt), 32'(pat[i]));
      check($sformatf("c%0d d_gnt", i),  32'(d_gnt),  32'(!pat[i]));
      if (i > 0) begin
        check($sformatf("c%0d if_rvalid", i), 32'(if_rvalid), 32'(prev_f));
        check($sformatf("c%0d d_rvalid", i),  32'(d_rvalid),  32'(!prev_f));
        check($sformatf("c%0d if_rdata", i),  if_rdata, prev_f ? IR : 32'h0);
        check($sformatf("c%0d d_rdata", i),   d_rdata,  prev_f ? 32'h0 : DR);
      end
      prev_f = pat[i];
    end

    @(negedge clk);
    if_req = 1'b0;
    d_req  = 1'b0;
    #1;
    check("tail sram_en", 32'(sram_en), 32'h0);
    check("tail d_rvalid", 32'(d_rvalid), 32'h1);
    check("tail d_rdata", d_rdata, DR);
    check("tail if_rvalid", 32'(if_rvalid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
